// File: rtl/uart_link_ctrl_pkg.sv
// Shared definitions for the ESP8266 UART link controller.
//  - default zxuno register indices for DATA and STAT
//  - STAT register bit positions
//  - TX sequencer state encoding and engine-presence timeout
package uart_link_ctrl_pkg;

  localparam logic [7:0] DefAddrData = 8'hC6;
  localparam logic [7:0] DefAddrStat = 8'hC7;

  // STAT = {rx_avail, tx_pend, ovf, ferr, uart_rts, txdrop, 2'b00}
  localparam int unsigned StatRxAvail = 7;
  localparam int unsigned StatTxPend  = 6;
  localparam int unsigned StatOvf     = 5;
  localparam int unsigned StatFerr    = 4;
  localparam int unsigned StatRts     = 3;
  localparam int unsigned StatTxDrop  = 2;

  // Cycles allowed in StWaitBusy before the tx engine is declared missing.
  localparam int unsigned TxTimeout = 16;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitBusy = 2'd1,
    StWaitDone = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_link_ctrl_rx_fifo.sv
// Synchronous RX byte FIFO with a combinational head read.
// Ports:
//  clk, rst_n   system clock, synchronous active-low reset
//  push_i       write wdata_i (ignored when full unless a pop happens the same cycle)
//  pop_i        drop the head entry (ignored when empty)
//  wdata_i      byte to write
//  rdata_o      current head entry (undefined content when empty)
//  count_o      number of stored entries, 0 .. 2**Aw
//  full_o       count_o == 2**Aw
//  empty_o      count_o == 0
module uart_link_ctrl_rx_fifo #(
  parameter int unsigned Aw = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o,
  output logic [Aw:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned Depth = 2 ** Aw;
  localparam logic [Aw:0]   CntOne = (Aw + 1)'(1);
  localparam logic [Aw:0]   CntFull = (Aw + 1)'(Depth);
  localparam logic [Aw-1:0] PtrOne = Aw'(1);

  // Storage is left without reset so it maps onto distributed RAM.
  logic [7:0] mem_q [Depth];

  logic [Aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [Aw:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // When full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr).
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_link_ctrl.sv
// UART link controller between the rx/tx byte engines and the ZX-UNO register bus.
// Buffers received bytes, drives uart_rts with hysteresis and sequences one TX byte at a time.
// Ports:
//  clk, rst_n            28 MHz system clock, synchronous active-low reset
//  zxuno_addr/regrd/regwr register bus index and level strobes; din write data
//  dout, oe_n            read data and output enable (low while DATA/STAT read)
//  rx_byte/rx_valid/rx_frame_err  rx engine byte, completion strobe, stop-bit error strobe
//  tx_byte/tx_start/tx_busy       tx engine byte, start strobe, busy status
//  uart_rts              flow control to peer (0 = ready, 1 = stop)
module uart_link_ctrl
  import uart_link_ctrl_pkg::*;
#(
  parameter logic [7:0]  ADDR_DATA = DefAddrData,
  parameter logic [7:0]  ADDR_STAT = DefAddrStat,
  parameter int unsigned FIFO_AW   = 6,
  parameter int unsigned RTS_HI    = 48,
  parameter int unsigned RTS_LO    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  output logic [7:0] tx_byte,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       uart_rts
);

  localparam logic [FIFO_AW:0] RtsHi = (FIFO_AW + 1)'(RTS_HI);
  localparam logic [FIFO_AW:0] RtsLo = (FIFO_AW + 1)'(RTS_LO);
  localparam logic [3:0]       ToLast = 4'(TxTimeout - 1);

  // Bus strobe decode and edge detection
  logic rd_data_cur, rd_stat_cur, wr_data_cur;
  logic rd_data_q, rd_stat_q, wr_data_q;
  logic pop_req, stat_clr, wr_rise;

  assign rd_data_cur = zxuno_regrd & (zxuno_addr == ADDR_DATA);
  assign rd_stat_cur = zxuno_regrd & (zxuno_addr == ADDR_STAT);
  assign wr_data_cur = zxuno_regwr & (zxuno_addr == ADDR_DATA);

  // Pops and flag clears happen once the CPU has finished sampling dout.
  assign pop_req  = rd_data_q & ~rd_data_cur;
  assign stat_clr = rd_stat_q & ~rd_stat_cur;
  assign wr_rise  = wr_data_cur & ~wr_data_q;

  // RX FIFO
  logic              push_req;
  logic [7:0]        fifo_head;
  logic [FIFO_AW:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              pop_ok;

  assign push_req = rx_valid & ~rx_frame_err;
  assign pop_ok   = pop_req & ~fifo_empty;

  uart_link_ctrl_rx_fifo #(
    .Aw (FIFO_AW)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .pop_i   (pop_req),
    .wdata_i (rx_byte),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // TX sequencer
  tx_state_e  state_q, state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_start_q, tx_start_d;
  logic [3:0] to_cnt_q, to_cnt_d;
  logic       tx_timeout, tx_overrun;
  logic       tx_pend;

  assign tx_pend = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = 1'b0;
    to_cnt_d   = to_cnt_q;
    tx_timeout = 1'b0;
    tx_overrun = 1'b0;
    case (state_q)
      StIdle: begin
        if (wr_rise) begin
          tx_byte_d  = din;
          tx_start_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = StWaitBusy;
        end
      end
      StWaitBusy: begin
        tx_overrun = wr_rise;
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (to_cnt_q == ToLast) begin
          // Engine never acknowledged: give up so the CPU is not blocked forever.
          tx_timeout = 1'b1;
          state_d    = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 4'd1;
        end
      end
      StWaitDone: begin
        tx_overrun = wr_rise;
        if (!tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky flags: a new event in the clearing cycle wins so it is never lost.
  logic ovf_q, ovf_d;
  logic ferr_q, ferr_d;
  logic txdrop_q, txdrop_d;
  logic ovf_set;

  assign ovf_set = push_req & fifo_full & ~pop_ok;

  always_comb begin
    ovf_d    = ovf_q;
    ferr_d   = ferr_q;
    txdrop_d = txdrop_q;
    if (stat_clr) begin
      ovf_d    = 1'b0;
      ferr_d   = 1'b0;
      txdrop_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
    if (rx_valid && rx_frame_err) begin
      ferr_d = 1'b1;
    end
    if (tx_timeout || tx_overrun) begin
      txdrop_d = 1'b1;
    end
  end

  // RTS follows the registered count, one cycle behind the push that crossed a threshold.
  logic rts_q, rts_d;

  always_comb begin
    rts_d = rts_q;
    if (fifo_count >= RtsHi) begin
      rts_d = 1'b1;
    end else if (fifo_count <= RtsLo) begin
      rts_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= 1'b0;
      rd_stat_q  <= 1'b0;
      wr_data_q  <= 1'b0;
      state_q    <= StIdle;
      tx_byte_q  <= 8'h00;
      tx_start_q <= 1'b0;
      to_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      txdrop_q   <= 1'b0;
      rts_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_cur;
      rd_stat_q  <= rd_stat_cur;
      wr_data_q  <= wr_data_cur;
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
      to_cnt_q   <= to_cnt_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
      txdrop_q   <= txdrop_d;
      rts_q      <= rts_d;
    end
  end

  // Register read path; only registered state reaches dout.
  logic [7:0] stat;

  always_comb begin
    stat              = 8'h00;
    stat[StatRxAvail] = ~fifo_empty;
    stat[StatTxPend]  = tx_pend;
    stat[StatOvf]     = ovf_q;
    stat[StatFerr]    = ferr_q;
    stat[StatRts]     = rts_q;
    stat[StatTxDrop]  = txdrop_q;
  end

  always_comb begin
    dout = 8'h00;
    if (rd_data_cur) begin
      dout = fifo_empty ? 8'h00 : fifo_head;
    end else if (rd_stat_cur) begin
      dout = stat;
    end
  end

  assign oe_n     = ~(rd_data_cur | rd_stat_cur);
  assign tx_byte  = tx_byte_q;
  assign tx_start = tx_start_q;
  assign uart_rts = rts_q;

endmodule
